// File: rtl/fetch_prefetch_if.sv
// fetch_prefetch_if: instruction-memory, decode and redirect signals of the fetch front end
interface fetch_prefetch_if #(
    parameter int ADDR_W = 32,
    parameter int HW_W   = 16
);
    logic              imem_rd;
    logic [ADDR_W-1:0] imem_addr;
    logic [HW_W-1:0]   imem_rdata;
    logic              instr_valid;
    logic              instr_ready;
    logic [2*HW_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_long;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;

    modport master (
        output imem_rd, imem_addr, instr_valid, instr, instr_pc, instr_long,
        input  imem_rdata, instr_ready, redirect, redirect_pc
    );
    modport slave (
        input  imem_rd, imem_addr, instr_valid, instr, instr_pc, instr_long,
        output imem_rdata, instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: halfword prefetch queue that assembles 16/32-bit instructions for decode
module fetch_prefetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                HW_W     = 16,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32),
    parameter int                LONG_BIT = 15
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    fetch_prefetch_if.master bus_io
);
    localparam int            PW   = $clog2(DEPTH);
    localparam int            CW   = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [HW_W-1:0]   hw_q [DEPTH];
    logic [ADDR_W-1:0] pc_q [DEPTH];
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PW-1:0]     head_q, head_d, head_nxt, tail;
    logic [CW-1:0]     count_q, count_d, pop_n;
    logic              inflight_q, inflight_d, discard_q, discard_d;
    logic              any, is_long, push, accept;

    always_comb begin
        any                = count_q != '0;
        head_nxt           = head_q + PW'(1);
        tail               = head_q + count_q[PW-1:0];
        is_long            = any && hw_q[head_q][LONG_BIT];
        push               = inflight_q && !discard_q;
        bus_io.instr_valid = is_long ? count_q >= CW'(2) : any;
        bus_io.instr_long  = is_long;
        bus_io.instr_pc    = any ? pc_q[head_q] : '0;
        bus_io.instr       = !any ? '0 : is_long ? {hw_q[head_q], hw_q[head_nxt]} : {hw_q[head_q], HW_W'(0)};
        accept             = bus_io.instr_valid && bus_io.instr_ready;
        pop_n              = accept ? (is_long ? CW'(2) : CW'(1)) : '0;
        // Consumption is not credited, so the request never depends on instr_ready.
        bus_io.imem_rd     = rst_ni && !bus_io.redirect && ((count_q + CW'(inflight_q)) < FULL);
        bus_io.imem_addr   = fetch_pc_q;
        fetch_pc_d         = bus_io.redirect ? bus_io.redirect_pc : fetch_pc_q + ADDR_W'(bus_io.imem_rd);
        inflight_d         = bus_io.imem_rd;
        discard_d          = bus_io.redirect && inflight_q;
        count_d            = bus_io.redirect ? '0 : count_q + CW'(push) - pop_n;
        head_d             = head_q + pop_n[PW-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_pc_q <= RESET_PC;
            head_q     <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
            discard_q  <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

    // A response always belongs to the address just behind fetch_pc; nothing reads the payload while empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            hw_q[tail] <= bus_io.imem_rdata;
            pc_q[tail] <= fetch_pc_q - ADDR_W'(1);
        end
    end
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb_fetch_prefetch_unit: directed and random fetch traffic checked against a halfword-queue model
module tb_fetch_prefetch_unit;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_prefetch_if #(.ADDR_W(32), .HW_W(16)) bus ();
    fetch_prefetch_if #(.ADDR_W(8),  .HW_W(16)) bus8 ();

    fetch_prefetch_unit dut (.clk_i(clk), .rst_ni(rst_n), .bus_io(bus));
    fetch_prefetch_unit #(.ADDR_W(8), .RESET_PC(8'hFF)) dut8 (.clk_i(clk), .rst_ni(rst_n), .bus_io(bus8));

    typedef struct packed { logic [15:0] hw; logic [31:0] a; } ent_t;
    ent_t        mq[$];
    logic [15:0] prog [logic [31:0]];
    logic [31:0] m_pc, m_pend_a, e_addr, e_pc, e_instr, r_a, s8_instr;
    logic        m_pend, e_rd, e_valid, e_long, r_v, r8_v, s8_valid, s8_long;
    logic [7:0]  r8_a, s8_addr, s8_pc;
    logic        found;
    int          total = 0, bad = 0, cyc = 0;

    function automatic logic [15:0] mem(input logic [31:0] a);
        logic [31:0] h;
        if (prog.exists(a)) return prog[a];
        h = (a ^ 32'h5bd1_e995) * 32'h9E37_79B1;
        return h[31:16];
    endfunction

    function automatic logic [15:0] mem8(input logic [7:0] a);
        return a == 8'hFF ? 16'h8123 : a == 8'h00 ? 16'h4567 : 16'h0001;
    endfunction

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc     = 32'd32;
        m_pend   = 1'b0;
        m_pend_a = '0;
    endtask

    task automatic check();
        int n;
        n        = mq.size();
        r_v      = bus.imem_rd;
        r_a      = bus.imem_addr;
        r8_v     = bus8.imem_rd;
        r8_a     = bus8.imem_addr;
        s8_addr  = bus8.imem_addr;
        s8_valid = bus8.instr_valid;
        s8_long  = bus8.instr_long;
        s8_instr = bus8.instr;
        s8_pc    = bus8.instr_pc;
        e_long   = 1'b0;
        e_pc     = '0;
        e_instr  = '0;
        if (n > 0) begin
            e_long  = mq[0].hw[15];
            e_pc    = mq[0].a;
            e_instr = {mq[0].hw, 16'h0};
            if (e_long && n > 1) e_instr = {mq[0].hw, mq[1].hw};
        end
        e_valid = n > (e_long ? 1 : 0);
        e_rd    = rst_n && !bus.redirect && (n + int'(m_pend) < 4);
        e_addr  = m_pc;
        cmp("imem_rd", bus.imem_rd, e_rd);
        cmp("imem_addr", bus.imem_addr, e_addr);
        cmp("instr_valid", bus.instr_valid, e_valid);
        if (e_valid || !rst_n) begin
            cmp("instr", bus.instr, e_instr);
            cmp("instr_pc", bus.instr_pc, e_pc);
            cmp("instr_long", bus.instr_long, e_long);
        end
    endtask

    task automatic update();
        if (!rst_n) model_reset();
        else if (bus.redirect) begin
            mq.delete();
            m_pend = 1'b0;
            m_pc   = bus.redirect_pc;
        end else begin
            if (e_valid && bus.instr_ready) repeat (e_long ? 2 : 1) void'(mq.pop_front());
            if (m_pend) mq.push_back({mem(m_pend_a), m_pend_a});
            m_pend = e_rd;
            if (e_rd) begin
                m_pend_a = m_pc;
                m_pc     = m_pc + 32'd1;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check();
        @(posedge clk);
        update();
        #1;
        bus.imem_rdata  = r_v ? mem(r_a) : 16'($urandom);
        bus8.imem_rdata = r8_v ? mem8(r8_a) : 16'($urandom);
        cyc++;
    endtask

    task automatic redirect_to(input logic [31:0] a);
        bus.redirect    = 1'b1;
        bus.redirect_pc = a;
        tick();
        cmp("redir_rd", e_rd, 0);
        bus.redirect = 1'b0;
    endtask

    task automatic do_reset(input int n);
        #2 rst_n = 1'b0;
        #1;
        cmp("rst_imem_rd", bus.imem_rd, 0);
        cmp("rst_imem_addr", bus.imem_addr, 32);
        cmp("rst_valid", bus.instr_valid, 0);
        cmp("rst_instr", bus.instr, 0);
        cmp("rst_pc", bus.instr_pc, 0);
        cmp("rst_long", bus.instr_long, 0);
        model_reset();
        repeat (n) tick();
        rst_n = 1'b1;
        cyc   = 1;
    endtask

    initial begin
        bus.instr_ready  = 1'b1;
        bus.redirect     = 1'b0;
        bus.redirect_pc  = '0;
        bus.imem_rdata   = '0;
        bus8.instr_ready = 1'b1;
        bus8.redirect    = 1'b0;
        bus8.redirect_pc = '0;
        bus8.imem_rdata  = '0;
        r_v  = 1'b0;
        r8_v = 1'b0;
        r_a  = '0;
        r8_a = '0;
        for (int i = 0; i < 8; i++) prog[32'd32 + 32'(i)] = 16'(i + 1);
        model_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        cyc   = 1;
        // straight line of short halfwords, plus the 8-bit wrap instance alongside
        tick();
        cmp("c1_rd", e_rd, 1);
        cmp("c1_addr", e_addr, 32);
        cmp("w8_c1_addr", s8_addr, 8'hFF);
        tick();
        tick();
        cmp("w8_c3_addr", s8_addr, 8'h01);
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) tick();
            cmp("line_valid", e_valid, 1);
            cmp("line_instr", e_instr, 32'(k) << 16);
            cmp("line_pc", e_pc, 32'(31 + k));
            if (k == 2) begin
                cmp("w8_long_valid", s8_valid, 1);
                cmp("w8_long", s8_long, 1);
                cmp("w8_instr", s8_instr, 32'h8123_4567);
                cmp("w8_pc", s8_pc, 8'hFF);
            end
            if (k == 3) begin
                cmp("w8_next_pc", s8_pc, 8'h01);
                cmp("w8_next_long", s8_long, 0);
            end
        end
        // long instruction at 32
        prog[32'd32] = 16'h8123;
        prog[32'd33] = 16'h4567;
        prog[32'd34] = 16'h0005;
        prog[32'd35] = 16'h0006;
        redirect_to(32'd32);
        repeat (3) tick();
        cmp("long_not_yet", e_valid, 0);
        tick();
        cmp("long_valid", e_valid, 1);
        cmp("long_flag", e_long, 1);
        cmp("long_instr", e_instr, 32'h8123_4567);
        cmp("long_pc", e_pc, 32);
        tick();
        cmp("after_long_pc", e_pc, 34);
        cmp("after_long_instr", e_instr, 32'h0005_0000);
        // redirect while the request to 40 is in flight
        for (int i = 0; i < 5; i++) prog[32'd36 + 32'(i)] = 16'h0011 + 16'(i);
        prog[32'h100] = 16'h0042;
        redirect_to(32'd36);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            found = e_rd && e_addr == 32'd40;
        end
        cmp("wait_req40", found, 1);
        redirect_to(32'h100);
        tick();
        cmp("redir_t1_rd", e_rd, 1);
        cmp("redir_t1_addr", e_addr, 32'h100);
        cmp("redir_t1_valid", e_valid, 0);
        tick();
        cmp("redir_t2_valid", e_valid, 0);
        tick();
        cmp("redir_t3_valid", e_valid, 1);
        cmp("redir_t3_pc", e_pc, 32'h100);
        cmp("redir_t3_instr", e_instr, 32'h0042_0000);
        // stall until full, then release
        bus.instr_ready = 1'b0;
        repeat (10) tick();
        cmp("stall_fill", mq.size(), 4);
        cmp("stall_rd", e_rd, 0);
        bus.instr_ready = 1'b1;
        repeat (12) tick();
        // reset with a full queue
        bus.instr_ready = 1'b0;
        repeat (8) tick();
        cmp("full_before_rst", mq.size(), 4);
        do_reset(3);
        bus.instr_ready = 1'b1;
        tick();
        cmp("restart_rd", e_rd, 1);
        cmp("restart_addr", r_a, 32);
        // random stalls, redirects (some near the address wrap) and resets
        for (int i = 0; i < 3000; i++) begin
            bus.instr_ready = $urandom_range(0, 3) != 0;
            bus.redirect    = $urandom_range(0, 24) == 0;
            bus.redirect_pc = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : $urandom;
            if ($urandom_range(0, 499) == 0) do_reset(2);
            tick();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
